register_file: RTL and testbench

Eight-entry, 16-bit general-purpose register file for the 16-bit processor datapath. It provides one synchronous write port and a dual-operand read port. The read port is a registered pipeline stage with a valid/ready handshake, so the operand-fetch stage can stall without losing data. It sits between the instruction decoder, which issues reads, and the ALU/writeback path, which issues writes. It is built from the same enable-gated 16-bit storage behaviour as the standalone `register` block.

---
 rtl/register_file_if.sv | 42 ++++
 rtl/register_file.sv | 118 +++++++++++
 tb/tb_register_file.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : register_file_if                                             |
// | Purpose   : Bundles the write port and the handshaked dual-operand read  |
// |             port of the register file.                                   |
// | Signals   : wr_en/wr_addr/wr_data        - synchronous write port        |
// |             rd_req/rd_addr_a/rd_addr_b   - read request and addresses    |
// |             rd_gnt                       - request accepted this cycle   |
// |             rd_valid/rd_ready            - output-stage handshake        |
// |             rd_data_a/rd_data_b          - registered operands           |
// | Modports  : master (decoder/writeback side), slave (register file)       |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface register_file_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_req;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic             rd_gnt;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_req, rd_addr_a, rd_addr_b, rd_ready,
    input  rd_gnt, rd_valid, rd_data_a, rd_data_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_req, rd_addr_a, rd_addr_b, rd_ready,
    output rd_gnt, rd_valid, rd_data_a, rd_data_b
  );
endinterface
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : register_file                                                |
// | Purpose   : DEPTH x WIDTH general-purpose register file with one         |
// |             synchronous write port and a registered dual-operand read    |
// |             port behind a valid/ready handshake.                         |
// | Ports     : clk   - rising-edge clock                                    |
// |             rst_n - asynchronous active-low reset (clears all state)     |
// |             bus   - register_file_if.slave (write port, read request,    |
// |                     rd_gnt, rd_valid/rd_ready, rd_data_a/rd_data_b)      |
// | Notes     : DEPTH must be a power of two and AW = clog2(DEPTH), so every |
// |             address decodes to a real entry.                             |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module register_file #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  register_file_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rd_data_a_q;
  logic [WIDTH-1:0] rd_data_b_q;
  logic [WIDTH-1:0] op_a_d;
  logic [WIDTH-1:0] op_b_d;
  logic [WIDTH-1:0] mem_w [DEPTH];

  // ------------------------------------------------------------------------
  // Storage: one enable-gated register per entry. Every entry, including
  // address 0, is an ordinary writable register.
  // ------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic             wr_hit;
    logic [WIDTH-1:0] entry_q;

    assign wr_hit = bus.wr_en && (bus.wr_addr == AW'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_q <= '0;
      end else if (wr_hit) begin
        entry_q <= bus.wr_data;
      end
    end

    assign mem_w[gi] = entry_q;
  end

  // ------------------------------------------------------------------------
  // Operand selection with write-to-read bypass: a write landing on the
  // same edge as the capture must be seen by the read, so a matching write
  // address forwards wr_data instead of the (stale) stored entry.
  // ------------------------------------------------------------------------
  always_comb begin
    op_a_d = mem_w[bus.rd_addr_a];
    op_b_d = mem_w[bus.rd_addr_b];
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
      op_a_d = bus.wr_data;
    end
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
      op_b_d = bus.wr_data;
    end
  end

  // ------------------------------------------------------------------------
  // Read-port state machine. The output data registers only load on an
  // accepted request, which gives snapshot semantics while stalled. On
  // FULL -> EMPTY the data keeps its last value (don't-care to consumers).
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (bus.rd_req) begin
            state_q     <= ST_FULL;
            rd_data_a_q <= op_a_d;
            rd_data_b_q <= op_b_d;
          end
        end
        ST_FULL: begin
          if (bus.rd_ready) begin
            if (bus.rd_req) begin
              // Back-to-back: consumer drains and a new read lands together.
              rd_data_a_q <= op_a_d;
              rd_data_b_q <= op_b_d;
            end else begin
              state_q <= ST_EMPTY;
            end
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  // Grant depends only on the output stage, never on addresses or data.
  assign bus.rd_gnt    = (state_q == ST_EMPTY) || bus.rd_ready;
  assign bus.rd_valid  = (state_q == ST_FULL);
  assign bus.rd_data_a = rd_data_a_q;
  assign bus.rd_data_b = rd_data_b_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_register_file                                             |
// | Purpose   : Self-checking bench for register_file: directed scenarios    |
// |             with literal expectations plus randomized traffic compared   |
// |             every cycle against a behavioural model.                     |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_register_file;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_total = 0;
  int n_bad   = 0;

  register_file_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------------------
  // Behavioural model: an array of entries plus a "holding a result" flag
  // and the two held operands. A write is applied to the array first, then
  // an accepted read samples the array, which yields the new-value-wins
  // behaviour for a coincident write.
  // ------------------------------------------------------------------------
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_a = '0;
  logic [WIDTH-1:0] m_b = '0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_valid = 1'b0;
        m_a     = '0;
        m_b     = '0;
      end else begin
        logic take;
        take = bus.rd_req && (!m_valid || bus.rd_ready);
        if (bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
        if (take) begin
          m_a     = m_mem[bus.rd_addr_a];
          m_b     = m_mem[bus.rd_addr_b];
          m_valid = 1'b1;
        end else if (bus.rd_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_valid", 32'(bus.rd_valid), 32'(m_valid));
      chk("cmp_gnt",   32'(bus.rd_gnt),   32'(!m_valid || bus.rd_ready));
      chk("cmp_a",     32'(bus.rd_data_a), 32'(m_a));
      chk("cmp_b",     32'(bus.rd_data_b), 32'(m_b));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_req    = 1'b0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    bus.rd_ready  = 1'b1;
  endtask

  task automatic write(input int addr, input logic [WIDTH-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = data;
    cyc();
    bus.wr_en   = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_req    = 1'b1;
      bus.rd_addr_a = AW'(i);
      bus.rd_addr_b = AW'(DEPTH - 1 - i);
      cyc();
      chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
      chk({tag, "_a"}, 32'(bus.rd_data_a), 32'h0000);
      chk({tag, "_b"}, 32'(bus.rd_data_b), 32'h0000);
    end
    bus.rd_req = 1'b0;
    cyc();
  endtask

  initial begin
    idle_inputs();
    #1 rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_gnt",   32'(bus.rd_gnt),   32'd1);
    chk("rst_a",     32'(bus.rd_data_a), 32'h0000);
    chk("rst_b",     32'(bus.rd_data_b), 32'h0000);
    read_all_zero("post_rst");

    // Write then read.
    write(2, 16'h0013);
    write(5, 16'h0031);
    bus.rd_req = 1'b1; bus.rd_addr_a = 3'd2; bus.rd_addr_b = 3'd5;
    cyc();
    chk("wr_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("wr_rd_a", 32'(bus.rd_data_a), 32'h0013);
    chk("wr_rd_b", 32'(bus.rd_data_b), 32'h0031);
    bus.rd_req = 1'b0;

    // Bypass with and without write enable.
    write(3, 16'h0001);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 16'hBEEF;
    bus.rd_req = 1'b1; bus.rd_addr_a = 3'd3; bus.rd_addr_b = 3'd3;
    cyc();
    chk("byp_a", 32'(bus.rd_data_a), 32'hBEEF);
    chk("byp_b", 32'(bus.rd_data_b), 32'hBEEF);
    bus.rd_req = 1'b0;
    write(3, 16'h0001);
    bus.wr_en = 1'b0; bus.wr_addr = 3'd3; bus.wr_data = 16'hBEEF;
    bus.rd_req = 1'b1; bus.rd_addr_a = 3'd3; bus.rd_addr_b = 3'd3;
    cyc();
    chk("nobyp_a", 32'(bus.rd_data_a), 32'h0001);
    chk("nobyp_b", 32'(bus.rd_data_b), 32'h0001);
    bus.rd_req = 1'b0;

    // Stall / hold with snapshot semantics.
    write(4, 16'h1234);
    bus.rd_req = 1'b1; bus.rd_addr_a = 3'd4; bus.rd_addr_b = 3'd4; bus.rd_ready = 1'b0;
    cyc();
    chk("stall_cap_a", 32'(bus.rd_data_a), 32'h1234);
    for (int k = 0; k < 3; k++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 16'h5678;
      bus.rd_req = 1'b1; bus.rd_addr_a = 3'd6; bus.rd_addr_b = 3'd6;
      #1;
      chk("stall_gnt", 32'(bus.rd_gnt), 32'd0);
      cyc();
      chk("stall_valid", 32'(bus.rd_valid), 32'd1);
      chk("stall_hold_a", 32'(bus.rd_data_a), 32'h1234);
      chk("stall_hold_b", 32'(bus.rd_data_b), 32'h1234);
    end
    bus.wr_en = 1'b0; bus.rd_ready = 1'b1;
    #1;
    chk("release_gnt", 32'(bus.rd_gnt), 32'd1);
    cyc();
    chk("release_a", 32'(bus.rd_data_a), 32'h0000);
    chk("release_valid", 32'(bus.rd_valid), 32'd1);
    bus.rd_addr_a = 3'd4; bus.rd_addr_b = 3'd4;
    cyc();
    chk("after_stall_a", 32'(bus.rd_data_a), 32'h5678);
    bus.rd_req = 1'b0;
    cyc();
    chk("drain_valid", 32'(bus.rd_valid), 32'd0);
    chk("drain_keep_a", 32'(bus.rd_data_a), 32'h5678);

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) write(i, 16'(16'h0010 + i));
    for (int i = 0; i < 4; i++) begin
      bus.rd_req = 1'b1; bus.rd_addr_a = AW'(i); bus.rd_addr_b = AW'(i);
      #1;
      chk("b2b_gnt", 32'(bus.rd_gnt), 32'd1);
      cyc();
      chk("b2b_valid", 32'(bus.rd_valid), 32'd1);
      chk("b2b_a", 32'(bus.rd_data_a), 32'h0010 + 32'(i));
    end
    bus.rd_req = 1'b0;
    cyc();

    // Enable gating: data on the write bus without wr_en must not land.
    bus.wr_en = 1'b0; bus.wr_addr = 3'd7; bus.wr_data = 16'hFFFF;
    repeat (5) cyc();
    bus.rd_req = 1'b1; bus.rd_addr_a = 3'd7; bus.rd_addr_b = 3'd7;
    cyc();
    chk("gate_a", 32'(bus.rd_data_a), 32'h0000);
    chk("gate_b", 32'(bus.rd_data_b), 32'h0000);
    bus.rd_req = 1'b0;
    cyc();

    // Asynchronous reset in the middle of a held read.
    bus.rd_req = 1'b1; bus.rd_addr_a = 3'd4; bus.rd_addr_b = 3'd2; bus.rd_ready = 1'b0;
    cyc();
    chk("pre_rst_valid", 32'(bus.rd_valid), 32'd1);
    chk("pre_rst_a", 32'(bus.rd_data_a), 32'h5678);
    bus.rd_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("mid_rst_gnt",   32'(bus.rd_gnt),   32'd1);
    chk("mid_rst_a",     32'(bus.rd_data_a), 32'h0000);
    chk("mid_rst_b",     32'(bus.rd_data_b), 32'h0000);
    repeat (2) cyc();
    rst_n = 1'b1;
    read_all_zero("mid_rst_clr");

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      bus.wr_en     = ($urandom_range(0, 1) == 1);
      bus.wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      bus.wr_data   = WIDTH'($urandom);
      bus.rd_req    = ($urandom_range(0, 3) != 0);
      bus.rd_addr_a = AW'($urandom_range(0, DEPTH - 1));
      bus.rd_addr_b = AW'($urandom_range(0, DEPTH - 1));
      bus.rd_ready  = ($urandom_range(0, 9) < 7);
      cyc();
    end
    idle_inputs();
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
